muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide unit with its own HI/LO register pair, sitting beside the execute-stage ALU. It accepts one MULT/MULTU/DIV/DIVU issue from execute and iterates one bit per cycle. It signals busy to the hazard logic so that dependent MFHI/MFLO instructions or a second multiply/divide stall, then commits HI/LO and pulses done. It also services MTHI/MTLO writes and aborts cleanly on a pipeline flush.

---
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Issue, flush, MTHI/MTLO and result bundle between execute stage and the multiply/divide unit.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             start_e;
    logic [1:0]       op_e;
    logic [WIDTH-1:0] src1_e;
    logic [WIDTH-1:0] src2_e;
    logic             flush_i;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_e, op_e, src1_e, src2_e, flush_i, hi_we, lo_we, wdata,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_e, op_e, src1_e, src2_e, flush_i, hi_we, lo_we, wdata,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Bit-serial MULT/MULTU/DIV/DIVU unit with private HI/LO, one bit per cycle,
// sign correction in a final FIX cycle; supports flush and MTHI/MTLO.
//
// state | meaning
// IDLE  | waiting for issue; MTHI/MTLO writes accepted
// MUL   | shift-add iteration, one multiplier bit per cycle
// DIV   | restoring-division iteration, one quotient bit per cycle
// FIX   | sign correction and HI/LO commit
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     raw1;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 div_zero;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 is_signed;
    logic                 s1_neg;
    logic                 s2_neg;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign is_signed = ~bus.op_e[0];
    assign s1_neg    = is_signed & bus.src1_e[WIDTH-1];
    assign s2_neg    = is_signed & bus.src2_e[WIDTH-1];
    assign mag1      = s1_neg ? -bus.src1_e : bus.src1_e;
    assign mag2      = s2_neg ? -bus.src2_e : bus.src2_e;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    // Shifted remainder needs one extra bit so the trial subtract cannot overflow.
    assign div_diff  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};

    assign prod_fix  = neg_res ? -acc : acc;
    assign quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            raw1     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start_e && !bus.flush_i) begin
                        is_div   <= bus.op_e[1];
                        neg_res  <= s1_neg ^ s2_neg;
                        neg_rem  <= s1_neg;
                        div_zero <= (bus.src2_e == '0);
                        raw1     <= bus.src1_e;
                        cnt      <= CW'(WIDTH);
                        busy_q   <= 1'b1;
                        if (bus.op_e[1]) begin
                            acc   <= {{WIDTH{1'b0}}, mag1};
                            opb   <= mag2;
                            state <= DIV;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, mag2};
                            opb   <= mag1;
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (bus.flush_i) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= FIX;
                    end
                end
                DIV: begin
                    if (bus.flush_i) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (div_diff[WIDTH])
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                        else
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush_i) begin
                        done_q <= 1'b1;
                        if (!is_div) begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            hi_q <= raw1;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, flush, MTHI/MTLO and reset.
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one issue strobe; returns at the falling edge just after the sampling edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_e    = op;
        bus.src1_e  = a;
        bus.src2_e  = b;
        bus.start_e = 1'b1;
        @(negedge clk);
        bus.start_e = 1'b0;
    endtask

    // Counts busy cycles (bounded) and reports whether done_o is up when busy drops.
    task automatic wait_done(output int busy_cycles, output logic got_done);
        busy_cycles = 0;
        while (bus.busy_o === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        got_done = bus.done_o;
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        tests_run++;
        if (bus.done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
        tests_run++;
        if (bus.hi_o !== 32'h0) begin tests_failed++; $display("FAIL reset_hi got=%h exp=0", bus.hi_o); end
        tests_run++;
        if (bus.lo_o !== 32'h0) begin tests_failed++; $display("FAIL reset_lo got=%h exp=0", bus.lo_o); end
    endtask

    task automatic test_multu_max();
        int n; logic d;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, d);
        tests_run++;
        if (n !== 33) begin tests_failed++; $display("FAIL multu_max_busy got=%0d exp=33", n); end
        tests_run++;
        if (d !== 1'b1) begin tests_failed++; $display("FAIL multu_max_done got=%b exp=1", d); end
        tests_run++;
        if (bus.hi_o !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_max_hi got=%h exp=fffffffe", bus.hi_o); end
        tests_run++;
        if (bus.lo_o !== 32'h0000_0001) begin tests_failed++; $display("FAIL multu_max_lo got=%h exp=00000001", bus.lo_o); end
        @(negedge clk);
        tests_run++;
        if (bus.done_o !== 1'b0) begin tests_failed++; $display("FAIL multu_max_done_pulse got=%b exp=0", bus.done_o); end
    endtask

    task automatic test_mult_signed();
        int n; logic d;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(n, d);
        tests_run++;
        if (d !== 1'b1 || n !== 33) begin tests_failed++; $display("FAIL mult_neg_lat got=%0d/%b exp=33/1", n, d); end
        tests_run++;
        if (bus.hi_o !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", bus.hi_o); end
        tests_run++;
        if (bus.lo_o !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", bus.lo_o); end
    endtask

    task automatic test_div_signed();
        int n; logic d;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, d);
        tests_run++;
        if (d !== 1'b1 || n !== 33) begin tests_failed++; $display("FAIL div_neg_lat got=%0d/%b exp=33/1", n, d); end
        tests_run++;
        if (bus.lo_o !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_neg_lo got=%h exp=fffffffd", bus.lo_o); end
        tests_run++;
        if (bus.hi_o !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_neg_hi got=%h exp=ffffffff", bus.hi_o); end
    endtask

    task automatic test_div_zero();
        int n; logic d;
        issue(2'b11, 32'd100, 32'd0);
        wait_done(n, d);
        tests_run++;
        if (d !== 1'b1 || n !== 33) begin tests_failed++; $display("FAIL divu_zero_lat got=%0d/%b exp=33/1", n, d); end
        tests_run++;
        if (bus.lo_o !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divu_zero_lo got=%h exp=ffffffff", bus.lo_o); end
        tests_run++;
        if (bus.hi_o !== 32'd100) begin tests_failed++; $display("FAIL divu_zero_hi got=%h exp=00000064", bus.hi_o); end
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_done(n, d);
        tests_run++;
        if (bus.lo_o !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_zero_lo got=%h exp=ffffffff", bus.lo_o); end
        tests_run++;
        if (bus.hi_o !== 32'hFFFF_FFFB) begin tests_failed++; $display("FAIL div_zero_hi got=%h exp=fffffffb", bus.hi_o); end
    endtask

    task automatic test_div_overflow();
        int n; logic d;
        @(negedge clk);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, d);
        tests_run++;
        if (bus.lo_o !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_ovf_lo got=%h exp=80000000", bus.lo_o); end
        tests_run++;
        if (bus.hi_o !== 32'h0) begin tests_failed++; $display("FAIL div_ovf_hi got=%h exp=00000000", bus.hi_o); end
    endtask

    task automatic test_flush();
        int dones;
        @(negedge clk);
        issue(2'b01, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got=%b exp=0", bus.busy_o); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o === 1'b1) dones++;
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 0) begin tests_failed++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
        tests_run++;
        if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h8000_0000) begin
            tests_failed++; $display("FAIL flush_hilo got=%h_%h exp=00000000_80000000", bus.hi_o, bus.lo_o);
        end
        bus.wdata = 32'h1234;
        bus.lo_we = 1'b1;
        @(negedge clk);
        bus.lo_we = 1'b0;
        tests_run++;
        if (bus.lo_o !== 32'h1234) begin tests_failed++; $display("FAIL mtlo got=%h exp=00001234", bus.lo_o); end
        bus.flush_i = 1'b1;
        issue(2'b01, 32'd3, 32'd3);
        bus.flush_i = 1'b0;
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL flush_start_idle got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_mt_writes();
        int n; logic d;
        bus.wdata = 32'hABCD;
        bus.hi_we = 1'b1;
        @(negedge clk);
        bus.hi_we = 1'b0;
        tests_run++;
        if (bus.hi_o !== 32'hABCD) begin tests_failed++; $display("FAIL mthi got=%h exp=0000abcd", bus.hi_o); end
        bus.wdata = 32'h5555;
        bus.hi_we = 1'b1;
        issue(2'b11, 32'd100, 32'd7);
        bus.hi_we = 1'b0;
        tests_run++;
        if (bus.hi_o !== 32'h5555 || bus.busy_o !== 1'b1) begin
            tests_failed++; $display("FAIL mthi_with_start got=%h/%b exp=00005555/1", bus.hi_o, bus.busy_o);
        end
        bus.wdata = 32'h9999;
        bus.lo_we = 1'b1;
        @(negedge clk);
        bus.lo_we = 1'b0;
        tests_run++;
        if (bus.lo_o !== 32'h1234) begin tests_failed++; $display("FAIL mtlo_busy got=%h exp=00001234", bus.lo_o); end
        wait_done(n, d);
        tests_run++;
        if (bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) begin
            tests_failed++; $display("FAIL divu_100_7 got=%h_%h exp=00000002_0000000e", bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_ignored_start();
        int n; logic d;
        @(negedge clk);
        issue(2'b11, 32'd1000, 32'd9);
        repeat (3) @(negedge clk);
        issue(2'b11, 32'd9, 32'd3);
        wait_done(n, d);
        tests_run++;
        if (n + 4 !== 33 || d !== 1'b1) begin tests_failed++; $display("FAIL ign_start_lat got=%0d/%b exp=33/1", n + 4, d); end
        tests_run++;
        if (bus.lo_o !== 32'd111 || bus.hi_o !== 32'd1) begin
            tests_failed++; $display("FAIL ign_start_result got=%h_%h exp=00000001_0000006f", bus.hi_o, bus.lo_o);
        end
        @(negedge clk);
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL ign_start_dropped got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_back_to_back();
        int n; logic d;
        issue(2'b01, 32'd2, 32'd3);
        wait_done(n, d);
        tests_run++;
        if (d !== 1'b1 || bus.lo_o !== 32'd6) begin tests_failed++; $display("FAIL b2b_first got=%h/%b exp=00000006/1", bus.lo_o, d); end
        issue(2'b01, 32'd4, 32'd5);
        wait_done(n, d);
        tests_run++;
        if (n !== 33 || d !== 1'b1) begin tests_failed++; $display("FAIL b2b_lat got=%0d/%b exp=33/1", n, d); end
        tests_run++;
        if (bus.lo_o !== 32'd20 || bus.hi_o !== 32'd0) begin
            tests_failed++; $display("FAIL b2b_second got=%h_%h exp=00000000_00000014", bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_reset_mid();
        int n; logic d; int dones;
        @(negedge clk);
        issue(2'b00, 32'd9, 32'hFFFF_FFFE);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy_o); end
        tests_run++;
        if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            tests_failed++; $display("FAIL rst_mid_hilo got=%h_%h exp=00000000_00000000", bus.hi_o, bus.lo_o);
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) dones++;
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) dones++;
        end
        tests_run++;
        if (dones !== 0) begin tests_failed++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
        issue(2'b01, 32'd2, 32'd3);
        wait_done(n, d);
        tests_run++;
        if (n !== 33 || d !== 1'b1 || bus.lo_o !== 32'd6) begin
            tests_failed++; $display("FAIL rst_then_multu got=%0d/%b/%h exp=33/1/00000006", n, d, bus.lo_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        bus.start_e  = 1'b0;
        bus.op_e     = 2'b00;
        bus.src1_e   = '0;
        bus.src2_e   = '0;
        bus.flush_i  = 1'b0;
        bus.hi_we    = 1'b0;
        bus.lo_we    = 1'b0;
        bus.wdata    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_multu_max();
        test_mult_signed();
        @(negedge clk);
        test_div_signed();
        @(negedge clk);
        test_div_zero();
        test_div_overflow();
        test_flush();
        test_mt_writes();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
